mux: RTL and testbench

MUX -- requirements
Module: mux

---
 rtl/mux_pkg.sv | 22 ++
 rtl/mux_sel_counter.sv | 49 ++++
 rtl/mux.sv | 98 +++++++++
 tb/tb_mux.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mux_pkg
//  Description : Shared constants and types for the mux block: default data
//                width, default Sel transition-counter width, and the data
//                word type at the default width.
//  Config      : MUX_PARITY_EN (optional registered parity output on mux)
//  Revision    : 1.0 - initial release
// ============================================================================
package mux_pkg;

    // Default width of the A, B, C and C_Reg data words.
    localparam int c_DEFAULT_WIDTH = 4;

    // Default width of the saturating Sel transition counter.
    localparam int c_DEFAULT_CNT_W = 8;

    // Data word at the default width.
    typedef logic [c_DEFAULT_WIDTH-1:0] data_t;

endpackage : mux_pkg
`default_nettype wire

// File: rtl/mux_sel_counter.sv
`default_nettype none
// ============================================================================
//  Module      : mux_sel_counter
//  Description : Tracks the Sel value sampled on the previous clock edge and
//                counts the edges on which Sel differs from it. The count
//                saturates at all-ones instead of wrapping.
//  Ports       : i_clk   - clock, rising-edge active
//                i_rst   - synchronous active-high reset
//                i_sel   - select line being observed
//                o_count - number of Sel transitions seen (saturating)
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_sel_counter
    import mux_pkg::*;
#(
    parameter int CNT_W = c_DEFAULT_CNT_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_sel,
    output logic [CNT_W-1:0] o_count
);

    logic             r_sel_prev;
    logic [CNT_W-1:0] r_count;
    logic             w_sel_change;
    logic             w_at_max;

    // Reset clears r_sel_prev, so the first edge out of reset compares
    // Sel against 0.
    assign w_sel_change = i_sel ^ r_sel_prev;
    assign w_at_max     = &r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sel_prev <= 1'b0;
            r_count    <= '0;
        end else begin
            r_sel_prev <= i_sel;
            if (w_sel_change && !w_at_max) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign o_count = r_count;

endmodule : mux_sel_counter
`default_nettype wire

// File: rtl/mux.sv
`default_nettype none
// ============================================================================
//  Module      : mux
//  Description : 2:1 data multiplexer with a combinational output, a
//                registered output qualified by In_Valid, a one-cycle-delayed
//                valid flag and a saturating count of Sel transitions.
//  Ports       : Clk       - clock, rising-edge active
//                Rst       - synchronous active-high reset
//                A         - operand selected when Sel = 0
//                B         - operand selected when Sel = 1
//                Sel       - select
//                In_Valid  - qualifies A/B/Sel for the registered path
//                C         - combinational mux result
//                C_Reg     - registered mux result (loads when In_Valid)
//                Out_Valid - In_Valid delayed by one cycle
//                Sel_Count - saturating number of Sel transitions
//                Par       - (MUX_PARITY_EN only) registered XOR-reduce of
//                            the value loaded into C_Reg
//  Config      : define MUX_PARITY_EN to add the Par output and its register
//  Revision    : 1.0 - initial release
// ============================================================================
module mux
    import mux_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH,
    parameter int CNT_W = c_DEFAULT_CNT_W
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Sel,
    input  logic             In_Valid,
    output logic [WIDTH-1:0] C,
    output logic [WIDTH-1:0] C_Reg,
    output logic             Out_Valid,
    output logic [CNT_W-1:0] Sel_Count
`ifdef MUX_PARITY_EN
    ,
    output logic             Par
`endif
);

    logic [WIDTH-1:0] w_mux;
    logic [WIDTH-1:0] r_c_reg;
    logic             r_out_valid;
    logic [CNT_W-1:0] w_sel_count;

    // Pure combinational select; Clk, Rst and In_Valid play no part in C.
    assign w_mux = Sel ? B : A;
    assign C     = w_mux;

    // Registered path. Rst wins over In_Valid, so a result pending on the
    // reset edge is dropped and Out_Valid is low on the following cycle.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_c_reg     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= In_Valid;
            if (In_Valid) begin
                r_c_reg <= w_mux;
            end
        end
    end

    assign C_Reg     = r_c_reg;
    assign Out_Valid = r_out_valid;

`ifdef MUX_PARITY_EN
    logic r_par;

    // Parity is taken from the value being loaded, so it changes on the same
    // edge as C_Reg and never lags it.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_par <= 1'b0;
        end else if (In_Valid) begin
            r_par <= ^w_mux;
        end
    end

    assign Par = r_par;
`endif

    mux_sel_counter #(
        .CNT_W (CNT_W)
    ) u_sel_counter (
        .i_clk   (Clk),
        .i_rst   (Rst),
        .i_sel   (Sel),
        .o_count (w_sel_count)
    );

    assign Sel_Count = w_sel_count;

endmodule : mux
`default_nettype wire

// File: tb/tb_mux.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mux
//  Description : Self-checking bench for mux. A reference model updated on
//                each rising edge pushes expected registered results into a
//                queue; a monitor on the falling edge pops them whenever
//                Out_Valid is high and also checks C, C_Reg hold, Out_Valid
//                and Sel_Count against the model. Directed sequences cover
//                reset, truncation, one-shot load, counter saturation, reset
//                during valid and (with MUX_PARITY_EN) parity.
//  Config      : MUX_PARITY_EN (also checks Par when defined)
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mux;

    localparam int WIDTH = 4;
    localparam int CNT_W = 8;
    localparam int DMOD  = 1 << WIDTH;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             Clk;
    logic             Rst;
    logic [7:0]       a_wide;
    logic [WIDTH-1:0] B;
    logic             Sel;
    logic             In_Valid;
    logic [WIDTH-1:0] C;
    logic [WIDTH-1:0] C_Reg;
    logic             Out_Valid;
    logic [CNT_W-1:0] Sel_Count;
`ifdef MUX_PARITY_EN
    logic             Par;
`endif

    mux #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .A         (a_wide[WIDTH-1:0]),
        .B         (B),
        .Sel       (Sel),
        .In_Valid  (In_Valid),
        .C         (C),
        .C_Reg     (C_Reg),
        .Out_Valid (Out_Valid),
        .Sel_Count (Sel_Count)
`ifdef MUX_PARITY_EN
        ,
        .Par       (Par)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at t=%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int c;
        int par;
    } exp_t;

    exp_t exp_q[$];
    int   m_prev = 0;
    int   m_cnt  = 0;
    int   m_creg = 0;
    int   m_par  = 0;
    int   m_ov   = 0;

    function automatic int sel_value(input int a, input int b, input int s);
        return (s != 0) ? (b % DMOD) : (a % DMOD);
    endfunction

    always @(posedge Clk) begin
        if (Rst) begin
            exp_q.delete();
            m_prev = 0;
            m_cnt  = 0;
            m_creg = 0;
            m_par  = 0;
            m_ov   = 0;
        end else begin
            if (int'(Sel) != m_prev && m_cnt < CMAX) m_cnt = m_cnt + 1;
            m_prev = int'(Sel);
            m_ov   = int'(In_Valid);
            if (In_Valid) begin
                exp_t e;
                e.c    = sel_value(int'(a_wide), int'(B), int'(Sel));
                e.par  = $countones(e.c) % 2;
                m_creg = e.c;
                m_par  = e.par;
                exp_q.push_back(e);
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge Clk) begin
        check("C_comb", int'(C), sel_value(int'(a_wide), int'(B), int'(Sel)));
        check("Out_Valid", int'(Out_Valid), m_ov);
        check("Sel_Count", int'(Sel_Count), m_cnt);
`ifdef MUX_PARITY_EN
        check("Par", int'(Par), m_par);
`endif
        if (Out_Valid) begin
            if (exp_q.size() == 0) begin
                check("Out_Valid_unexpected", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("C_Reg_result", int'(C_Reg), e.c);
            end
        end else begin
            check("C_Reg_hold", int'(C_Reg), m_creg);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Rst      = 1'b1;
        In_Valid = 1'b0;
        Sel      = 1'b0;
        a_wide   = 8'h00;
        B        = '0;

        // Reset state
        step();
        step();
        @(negedge Clk);
        check("rst_C_Reg", int'(C_Reg), 0);
        check("rst_Out_Valid", int'(Out_Valid), 0);
        check("rst_Sel_Count", int'(Sel_Count), 0);
        step();
        Rst = 1'b0;

        // Combinational select without waiting for a clock edge
        a_wide = 8'h03;
        B      = 4'hC;
        Sel    = 1'b0;
        #1;
        check("C_sel0", int'(C), 'h3);
        Sel = 1'b1;
        #1;
        check("C_sel1", int'(C), 'hC);

        // Truncation of a wider source onto A
        a_wide = 8'hA7;
        Sel    = 1'b0;
        #1;
        check("C_trunc", int'(C), 'h7);

        // One-shot load, then hold
        step();
        a_wide   = 8'h05;
        Sel      = 1'b0;
        In_Valid = 1'b1;
        step();
        In_Valid = 1'b0;
        a_wide   = 8'h09;
        @(negedge Clk);
        check("load_C_Reg", int'(C_Reg), 'h5);
        check("load_Out_Valid", int'(Out_Valid), 1);
        step();
        @(negedge Clk);
        check("after_Out_Valid", int'(Out_Valid), 0);
        check("hold_C_Reg", int'(C_Reg), 'h5);

        // Sel toggling on every edge: count follows, then saturates
        step();
        Sel = 1'b0;
        Rst = 1'b1;
        step();
        Rst = 1'b0;
        for (int i = 0; i < 300; i++) begin
            Sel = ~Sel;
            step();
            if (i == 99) begin
                @(negedge Clk);
                check("count_100", int'(Sel_Count), 100);
            end
        end
        @(negedge Clk);
        check("count_sat", int'(Sel_Count), CMAX);

        // Reset while a valid input is presented
        step();
        In_Valid = 1'b1;
        a_wide   = 8'($urandom);
        B        = WIDTH'($urandom);
        Sel      = 1'($urandom);
        Rst      = 1'b1;
        step();
        Rst      = 1'b0;
        In_Valid = 1'b0;
        @(negedge Clk);
        check("rstv_C_Reg", int'(C_Reg), 0);
        check("rstv_Out_Valid", int'(Out_Valid), 0);
        check("rstv_Sel_Count", int'(Sel_Count), 0);
        check("rstv_C", int'(C), sel_value(int'(a_wide), int'(B), int'(Sel)));

`ifdef MUX_PARITY_EN
        // Parity of loaded values
        step();
        In_Valid = 1'b1;
        Sel      = 1'b0;
        a_wide   = 8'h0B;
        step();
        a_wide = 8'h06;
        @(negedge Clk);
        check("par_B", int'(Par), 1);
        step();
        In_Valid = 1'b0;
        @(negedge Clk);
        check("par_6", int'(Par), 0);
`endif

        // Randomised traffic with occasional mid-stream resets
        for (int i = 0; i < 400; i++) begin
            step();
            Rst      = ($urandom_range(0, 39) == 0);
            In_Valid = 1'($urandom_range(0, 1));
            a_wide   = 8'($urandom);
            B        = WIDTH'($urandom);
            Sel      = 1'($urandom_range(0, 1));
        end

        step();
        Rst      = 1'b0;
        In_Valid = 1'b0;
        step();
        step();
        @(negedge Clk);
        check("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_mux
`default_nettype wire
